// File: rtl/tmr_cap_sel_reg.sv
// Triplicated storage for the PLL AFC capacitor-bank select code, with a
// periodic scrubber that repairs a single corrupted copy and counts repairs.
module tmr_cap_sel_reg #(
  parameter int unsigned         WIDTH        = 3,
  parameter logic [WIDTH-1:0]    RST_VAL      = WIDTH'(3'b011),
  parameter int unsigned         SCRUB_PERIOD = 16,
  parameter int unsigned         ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic [WIDTH-1:0]     din,
  input  logic                 scrub_en,
  input  logic                 err_clr,
  input  logic                 inj_en,
  input  logic [1:0]           inj_sel,
  input  logic [WIDTH-1:0]     inj_mask,
  output logic [WIDTH-1:0]     q_a,
  output logic [WIDTH-1:0]     q_b,
  output logic [WIDTH-1:0]     q_c,
  output logic [WIDTH-1:0]     q_voted,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 scrub_busy
);

  localparam int unsigned          CNT_W      = 8;
  localparam logic [CNT_W-1:0]     CNT_RELOAD = CNT_W'(SCRUB_PERIOD - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_REPAIR = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_copy_a;
  logic [WIDTH-1:0]     r_copy_b;
  logic [WIDTH-1:0]     r_copy_c;
  logic                 r_mismatch;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 r_busy;

  logic [WIDTH-1:0]     w_maj;
  logic                 w_diff;

  // Bitwise 2-of-3 vote; a single bad copy can never reach the output.
  always_comb begin
    w_maj  = (r_copy_a & r_copy_b) | (r_copy_b & r_copy_c) | (r_copy_a & r_copy_c);
    w_diff = (r_copy_a != r_copy_b) | (r_copy_b != r_copy_c);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_RELOAD;
      r_copy_a   <= RST_VAL;
      r_copy_b   <= RST_VAL;
      r_copy_c   <= RST_VAL;
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_mismatch <= w_diff;

      // Copy update: load beats repair beats injection.
      if (load) begin
        r_copy_a <= din;
        r_copy_b <= din;
        r_copy_c <= din;
      end else if (r_state == S_REPAIR) begin
        r_copy_a <= w_maj;
        r_copy_b <= w_maj;
        r_copy_c <= w_maj;
      end else if (inj_en) begin
        case (inj_sel)
          2'd0:    r_copy_a <= r_copy_a ^ inj_mask;
          2'd1:    r_copy_b <= r_copy_b ^ inj_mask;
          2'd2:    r_copy_c <= r_copy_c ^ inj_mask;
          default: ;
        endcase
      end

      // Scrub sequencer; a load restarts the period from scratch.
      if (load) begin
        r_state <= S_IDLE;
        r_cnt   <= CNT_RELOAD;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (scrub_en) begin
              if (r_cnt == '0) begin
                r_state <= S_CHECK;
                r_cnt   <= CNT_RELOAD;
                r_busy  <= 1'b1;
              end else begin
                r_cnt <= r_cnt - CNT_W'(1);
              end
            end
          end
          S_CHECK: begin
            if (w_diff) begin
              r_state <= S_REPAIR;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_REPAIR: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end

      // Repair counter saturates; clear always wins.
      if (err_clr) begin
        r_err_cnt <= '0;
      end else if ((r_state == S_REPAIR) && !load && (r_err_cnt != ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign q_a        = r_copy_a;
  assign q_b        = r_copy_b;
  assign q_c        = r_copy_c;
  assign q_voted    = w_maj;
  assign mismatch   = r_mismatch;
  assign err_cnt    = r_err_cnt;
  assign scrub_busy = r_busy;

endmodule

// File: tb/tb_tmr_cap_sel_reg.sv
// Bench for tmr_cap_sel_reg: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the register.
module tb_tmr_cap_sel_reg;

  localparam int P      = 8;
  localparam int ERRMAX = 255;

  logic       clk;
  logic       rstn;
  logic       load;
  logic [2:0] din;
  logic       scrub_en;
  logic       err_clr;
  logic       inj_en;
  logic [1:0] inj_sel;
  logic [2:0] inj_mask;
  logic [2:0] q_a, q_b, q_c, q_voted;
  logic       mismatch;
  logic [7:0] err_cnt;
  logic       scrub_busy;

  tmr_cap_sel_reg #(
    .WIDTH(3), .RST_VAL(3'b011), .SCRUB_PERIOD(P), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rstn(rstn), .load(load), .din(din), .scrub_en(scrub_en),
    .err_clr(err_clr), .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask),
    .q_a(q_a), .q_b(q_b), .q_c(q_c), .q_voted(q_voted), .mismatch(mismatch),
    .err_cnt(err_cnt), .scrub_busy(scrub_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: three copies, scrub phase (0 idle, 1 check, 2 repair), countdown.
  logic [2:0] m_cp [3];
  int         m_phase;
  int         m_cnt;
  int         m_err;
  bit         m_mis;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_vote(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] c);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cp[i] = 3'b011;
    m_phase = 0;
    m_cnt   = P - 1;
    m_err   = 0;
    m_mis   = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] maj;
    bit         differ;
    int         ph;
    maj    = ref_vote(m_cp[0], m_cp[1], m_cp[2]);
    differ = !((m_cp[0] == m_cp[1]) && (m_cp[1] == m_cp[2]));
    ph     = m_phase;
    m_mis  = differ;
    if (load) begin
      for (int i = 0; i < 3; i++) m_cp[i] = din;
    end else if (ph == 2) begin
      for (int i = 0; i < 3; i++) m_cp[i] = maj;
    end else if (inj_en && inj_sel != 2'd3) begin
      m_cp[int'(inj_sel)] = m_cp[int'(inj_sel)] ^ inj_mask;
    end
    if (err_clr) m_err = 0;
    else if (ph == 2 && !load && m_err < ERRMAX) m_err = m_err + 1;
    if (load) begin
      m_phase = 0;
      m_cnt   = P - 1;
    end else if (ph == 0) begin
      if (scrub_en) begin
        if (m_cnt == 0) begin
          m_phase = 1;
          m_cnt   = P - 1;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end else if (ph == 1) begin
      m_phase = differ ? 2 : 0;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_qa"}, 32'(q_a), 32'(m_cp[0]));
    check_eq({tag, "_qb"}, 32'(q_b), 32'(m_cp[1]));
    check_eq({tag, "_qc"}, 32'(q_c), 32'(m_cp[2]));
    check_eq({tag, "_qv"}, 32'(q_voted), 32'(ref_vote(m_cp[0], m_cp[1], m_cp[2])));
    check_eq({tag, "_mis"}, 32'(mismatch), 32'(m_mis));
    check_eq({tag, "_err"}, 32'(err_cnt), 32'(m_err));
    check_eq({tag, "_busy"}, 32'(scrub_busy), 32'(m_phase != 0));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    load = 1'b0; inj_en = 1'b0; err_clr = 1'b0;
    inj_sel = 2'd3; inj_mask = 3'b000;
  endtask

  // Step until the model reaches the given phase, within a cycle budget.
  task automatic wait_phase(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (m_phase != target && k < budget) begin
      step(tag);
      k++;
    end
    check_eq({tag, "_reached"}, 32'(m_phase), 32'(target));
  endtask

  initial begin
    logic [2:0] sel3;
    int         e0;
    rstn = 1'b0; din = 3'b000; scrub_en = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");
    rstn = 1'b1;

    // Async reset mid-operation after loading 101.
    load = 1'b1; din = 3'b101;
    step("load101");
    idle_inputs();
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_eq("async_qa", 32'(q_a), 32'h3);
    check_eq("async_qb", 32'(q_b), 32'h3);
    check_eq("async_qc", 32'(q_c), 32'h3);
    check_all("async");
    #2 rstn = 1'b1;

    // Load 110 with scrubbing off.
    load = 1'b1; din = 3'b110;
    step("load110");
    idle_inputs();
    check_eq("load110_qv", 32'(q_voted), 32'h6);
    step("hold110");
    check_eq("hold110_mis", 32'(mismatch), 32'h0);

    // Single upset on B, repaired by the scrubber.
    scrub_en = 1'b1;
    inj_en = 1'b1; inj_sel = 2'd1; inj_mask = 3'b001;
    step("injB");
    idle_inputs();
    check_eq("injB_qb", 32'(q_b), 32'h7);
    check_eq("injB_qv", 32'(q_voted), 32'h6);
    step("injB_mis");
    check_eq("injB_mis1", 32'(mismatch), 32'h1);
    wait_phase("toRepB", 2, 2 * P + 4);
    step("repB");
    step("repB_after");
    check_eq("repB_qb", 32'(q_b), 32'h6);
    check_eq("repB_err", 32'(err_cnt), 32'h1);
    check_eq("repB_mis", 32'(mismatch), 32'h0);

    // Double upset of the same bit: the vote follows the corrupted value.
    load = 1'b1; din = 3'b011;
    step("load011");
    idle_inputs();
    inj_en = 1'b1; inj_sel = 2'd0; inj_mask = 3'b100;
    step("injA");
    inj_sel = 2'd2;
    step("injC");
    idle_inputs();
    check_eq("dbl_qv", 32'(q_voted), 32'h7);
    wait_phase("toRepD", 2, 2 * P + 4);
    step("repD");
    check_eq("repD_qa", 32'(q_a), 32'h7);
    check_eq("repD_qb", 32'(q_b), 32'h7);
    check_eq("repD_qc", 32'(q_c), 32'h7);
    check_eq("repD_err", 32'(err_cnt), 32'h2);

    // Load wins over a coincident injection and an in-flight repair.
    inj_en = 1'b1; inj_sel = 2'd1; inj_mask = 3'b010;
    step("injL");
    idle_inputs();
    wait_phase("toRepL", 2, 2 * P + 4);
    e0 = m_err;
    load = 1'b1; din = 3'b010; inj_en = 1'b1; inj_sel = 2'd0; inj_mask = 3'b111;
    step("loadwin");
    idle_inputs();
    check_eq("loadwin_qa", 32'(q_a), 32'h2);
    check_eq("loadwin_err", 32'(err_cnt), 32'(e0));
    check_eq("loadwin_busy", 32'(scrub_busy), 32'h0);
    for (int i = 0; i < P + 2; i++) step("reload");

    // Drive the repair counter into saturation.
    for (int n = 0; n < 260; n++) begin
      inj_en = 1'b1;
      sel3 = 3'($urandom_range(0, 2));
      inj_sel = sel3[1:0];
      inj_mask = 3'($urandom_range(1, 7));
      step("satinj");
      idle_inputs();
      wait_phase("sat", 2, 3 * P + 4);
      step("satrep");
    end
    check_eq("sat_err", 32'(err_cnt), 32'(ERRMAX));

    // Clear coincident with a repair increment.
    inj_en = 1'b1; inj_sel = 2'd2; inj_mask = 3'b001;
    step("clrinj");
    idle_inputs();
    wait_phase("toRepClr", 2, 3 * P + 4);
    err_clr = 1'b1;
    step("clrrep");
    err_clr = 1'b0;
    check_eq("clr_err", 32'(err_cnt), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      load     = ($urandom_range(0, 99) < 5);
      din      = 3'($urandom);
      scrub_en = ($urandom_range(0, 99) < 90);
      err_clr  = ($urandom_range(0, 99) < 3);
      inj_en   = ($urandom_range(0, 99) < 20);
      inj_sel  = 2'($urandom);
      inj_mask = 3'($urandom);
      step("rand");
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tmr_cap_sel_reg.md
Name: tmr_cap_sel_reg

Overview:
- Triplicated (TMR) storage register for the PLL AFC capacitor-bank select code.
- Drives the three redundant copies A/B/C into the downstream bitwise majority voter.
- Runs a periodic scrubber that detects and repairs a corrupted copy and counts repairs.
- Sits between the AFC calibration FSM (writer) and the voter and VCO cap bank (reader).

Parameters:
- WIDTH, 3: code width in bits.
- RST_VAL, 3'b011: reset and default code; mid-band cap setting.
- SCRUB_PERIOD, 16: cycles between scrub checks; valid range 2..255.
- ERR_CNT_W, 8: repair counter width.

Ports:
- clk  input  1  single clock domain.
- rstn  input  1  asynchronous, active-low reset.
- load  input  1  write din into all three copies.
- din  input  WIDTH  new code from the AFC FSM.
- scrub_en  input  1  enables the periodic scrubber.
- err_clr  input  1  synchronous clear of err_cnt.
- inj_en  input  1  SEU injection strobe (test only).
- inj_sel  input  2  copy to upset: 0=A, 1=B, 2=C, 3=none.
- inj_mask  input  WIDTH  bits to flip in the selected copy.
- q_a  output  WIDTH  copy A, to the voter.
- q_b  output  WIDTH  copy B, to the voter.
- q_c  output  WIDTH  copy C, to the voter.
- q_voted  output  WIDTH  bitwise majority of the copies, combinational from the copy registers.
- mismatch  output  1  registered flag: copies not all equal.
- err_cnt  output  ERR_CNT_W  saturating count of repairs.
- scrub_busy  output  1  high in CHECK or REPAIR.

Behaviour:
- Reset (rstn low, async):
  - copy_a, copy_b, copy_c = RST_VAL.
  - mismatch=0, err_cnt=0, scrub_busy=0.
  - FSM = IDLE; period counter = SCRUB_PERIOD-1.
- Write priority per cycle: load > repair > inject.
- load=1:
  - All three copies take din at the next edge; q_* reflect din 1 cycle later.
  - FSM forced to IDLE; period counter reloads SCRUB_PERIOD-1.
  - A coincident inj_en is discarded.
- Inject (inj_en=1, load=0, FSM not in REPAIR):
  - Selected copy <= copy XOR inj_mask. inj_sel=3 has no effect.
  - Inject during REPAIR is discarded.
- mismatch <= (copy_a!=copy_b) | (copy_b!=copy_c), updated every cycle; 1 cycle after the copies change.
- Scrub FSM:
  - IDLE: if scrub_en, counter decrements. At 0 and scrub_en, go to CHECK and reload the counter. If scrub_en=0, the counter holds its value.
  - CHECK (1 cycle): if the copies differ, go to REPAIR; else go to IDLE.
  - REPAIR (1 cycle): all copies <= bitwise majority; err_cnt += 1, saturating at all-ones; go to IDLE.
  - scrub_en deassert mid-CHECK/REPAIR: the sequence completes, then holds in IDLE.
- Repair latency: copies identical 2 edges after entering CHECK; mismatch clears 1 cycle after that.
- Double upset on the same bit in two copies: majority takes the corrupted value; repair makes all copies equal to it; counted once. This is a known TMR limit, not flagged separately.
- err_clr: err_cnt <= 0. err_clr in the same cycle as a REPAIR increment gives 0 (clear wins).
- q_voted is valid at all times, including during REPAIR, and never glitches to a minority value when only one copy is corrupt.

Test Plan:
- Reset with rstn pulsed low mid-operation, asynchronously (no clock edge), after a load of 3'b101 -> q_a=q_b=q_c=3'b011 immediately; err_cnt=0; mismatch=0; FSM IDLE.
- load=1, din=3'b110, scrub_en=0 -> one cycle later all copies=3'b110, q_voted=3'b110, mismatch stays 0.
- scrub_en=1; inject inj_sel=1, mask=3'b001 on code 3'b110 -> q_b=3'b111, q_voted=3'b110, mismatch=1 next cycle; at the next scrub check: CHECK then REPAIR, q_b=3'b110, err_cnt=1, mismatch=0.
- Inject inj_sel=0 and then inj_sel=2, both with mask 3'b100, on code 3'b011 -> q_voted=3'b111; after the scrub, all copies=3'b111, err_cnt +1.
- load asserted in the same cycle as inj_en and a pending REPAIR -> copies=din, no flip, err_cnt unchanged, FSM IDLE, counter reloaded.
- Run 260 repairs with ERR_CNT_W=8 -> err_cnt saturates at 255; err_clr coincident with a REPAIR -> err_cnt=0.
